// File: rtl/writeback_stage_pkg.sv
// Shared writeback-select and load-size codes (also consumed by decode).
package writeback_stage_pkg;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // Context of a load parked while its data is outstanding.
   typedef struct packed {
      logic [4:0] rd;
      logic       regwren;
      logic [2:0] funct3;
      logic [1:0] offset;
   } load_ctx_t;

endpackage

// File: rtl/writeback_stage_load_extend.sv
// Combinational load extraction: shift raw word by byte offset, then size/sign-extend.
module writeback_stage_load_extend
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH = 32
) (
   input  logic [2:0]        funct3,
   input  logic [1:0]        offset,
   input  logic [DWIDTH-1:0] rdata,
   output logic [DWIDTH-1:0] data
);

   logic [7:0]  b;
   logic [15:0] h;

   // Misaligned halfword at offset 3 gets zeros shifted into its upper byte.
   assign b = 8'(rdata >> {offset, 3'b000});
   assign h = 16'(rdata >> {offset, 3'b000});

   always_comb begin
      case (funct3)
         F3_LB:   data = {{(DWIDTH-8){b[7]}}, b};
         F3_LBU:  data = {{(DWIDTH-8){1'b0}}, b};
         F3_LH:   data = {{(DWIDTH-16){h[15]}}, h};
         F3_LHU:  data = {{(DWIDTH-16){1'b0}}, h};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: selects ALU / load / PC+4 result and registers one commit per cycle.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module writeback_stage
   import writeback_stage_pkg::*;
#(
   parameter int DWIDTH = 32,
   parameter int CNTW   = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [4:0]        rd_i,
   input  logic              regwren_i,
   input  logic [1:0]        wbsel_i,
   input  logic [2:0]        funct3_i,
   input  logic [DWIDTH-1:0] alu_res_i,
   input  logic [DWIDTH-1:0] pc_i,
   input  logic              dmem_rvalid_i,
   input  logic [DWIDTH-1:0] dmem_rdata_i,
   output logic [4:0]        rd_o,
   output logic [DWIDTH-1:0] datawb_o,
   output logic              regwren_o,
   output logic              retire_o,
   output logic [CNTW-1:0]   instret_o
);

   localparam logic [0:0] S_IDLE     = 1'b0;
   localparam logic [0:0] S_WAIT_MEM = 1'b1;

   logic [0:0]        state, state_n;
   load_ctx_t         ctx, ctx_n;
   logic [DWIDTH-1:0] ld_data;
   logic              commit;
   logic [4:0]        c_rd;
   logic              c_wren;
   logic [DWIDTH-1:0] c_data;

   writeback_stage_load_extend #(.DWIDTH(DWIDTH)) u_load_extend (
      .funct3 (ctx.funct3),
      .offset (ctx.offset),
      .rdata  (dmem_rdata_i),
      .data   (ld_data)
   );

   assign ready_o = (state == S_IDLE);

   always_comb begin
      state_n = state;
      ctx_n   = ctx;
      commit  = 1'b0;
      c_rd    = rd_o;
      c_wren  = 1'b0;
      c_data  = datawb_o;
      case (state)
         S_IDLE: begin
            if (valid_i) begin
               if (wbsel_i == WB_MEM) begin
                  ctx_n   = '{rd: rd_i, regwren: regwren_i, funct3: funct3_i, offset: alu_res_i[1:0]};
                  state_n = S_WAIT_MEM;
               end else begin
                  // Reserved select code 3 falls through to the ALU result.
                  commit = 1'b1;
                  c_rd   = rd_i;
                  c_wren = regwren_i;
                  c_data = (wbsel_i == WB_PC4) ? pc_i + DWIDTH'(4) : alu_res_i;
               end
            end
         end
         default: begin
            if (dmem_rvalid_i) begin
               commit  = 1'b1;
               c_rd    = ctx.rd;
               c_wren  = ctx.regwren;
               c_data  = ld_data;
               state_n = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= S_IDLE;
         ctx       <= '0;
         rd_o      <= '0;
         datawb_o  <= '0;
         regwren_o <= 1'b0;
         retire_o  <= 1'b0;
      end else begin
         state     <= state_n;
         ctx       <= ctx_n;
         rd_o      <= c_rd;
         datawb_o  <= c_data;
         regwren_o <= commit && c_wren && (c_rd != 5'd0);
         retire_o  <= commit;
      end
   end

`ifdef WB_RETIRE_CNT_EN
   logic [CNTW-1:0] instret_q;

   // Counts on the commit edge so instret_o already includes the retire being shown.
   always_ff @(posedge clk) begin
      if (!rst)        instret_q <= '0;
      else if (commit) instret_q <= instret_q + 1'b1;
   end

   assign instret_o = instret_q;
`else
   assign instret_o = '0;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized + directed bench for writeback_stage against a behavioural commit model.
module tb_writeback_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_i, ready_o, regwren_i, dmem_rvalid_i;
   logic [4:0]  rd_i, rd_o;
   logic [1:0]  wbsel_i;
   logic [2:0]  funct3_i;
   logic [31:0] alu_res_i, pc_i, dmem_rdata_i, datawb_o;
   logic        regwren_o, retire_o;
   logic [63:0] instret_o;

   int total = 0;
   int bad   = 0;

   // Model: a pending load (if any) plus the expected registered outputs.
   bit          m_busy;
   logic [4:0]  m_rd;
   bit          m_wren;
   logic [2:0]  m_f3;
   logic [1:0]  m_off;
   logic [4:0]  e_rd;
   logic [31:0] e_data;
   bit          e_wren, e_retire;
   logic [63:0] m_cnt;

   writeback_stage #(.DWIDTH(32), .CNTW(64)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .rd_i(rd_i),
      .regwren_i(regwren_i), .wbsel_i(wbsel_i), .funct3_i(funct3_i), .alu_res_i(alu_res_i),
      .pc_i(pc_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i), .rd_o(rd_o),
      .datawb_o(datawb_o), .regwren_o(regwren_o), .retire_o(retire_o), .instret_o(instret_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
      int unsigned s, bv, hv;
      s  = w >> (8 * off);
      bv = s % 256;
      hv = s % 65536;
      case (f3)
         3'b000:  return (bv >= 128) ? bv - 256 : bv;
         3'b100:  return bv;
         3'b001:  return (hv >= 32768) ? hv - 65536 : hv;
         3'b101:  return hv;
         default: return w;
      endcase
   endfunction

   function automatic logic [63:0] exp_instret();
`ifdef WB_RETIRE_CNT_EN
      return m_cnt;
`else
      return 64'd0;
`endif
   endfunction

   task automatic do_commit(input logic [4:0] r, input bit w, input logic [31:0] d);
      e_rd = r; e_data = d; e_retire = 1; e_wren = w && (r != 0); m_cnt = m_cnt + 1;
   endtask

   // Evaluates the model on the inputs currently driven, then advances one clock.
   task automatic tick();
      if (!rst) begin
         m_busy = 0; e_rd = 0; e_data = 0; e_wren = 0; e_retire = 0; m_cnt = 0;
      end else begin
         e_wren = 0; e_retire = 0;
         if (!m_busy) begin
            if (valid_i) begin
               if (wbsel_i == 2'd1) begin
                  m_busy = 1; m_rd = rd_i; m_wren = regwren_i; m_f3 = funct3_i; m_off = alu_res_i[1:0];
               end else
                  do_commit(rd_i, regwren_i, (wbsel_i == 2'd2) ? pc_i + 32'd4 : alu_res_i);
            end
         end else if (dmem_rvalid_i) begin
            do_commit(m_rd, m_wren, ref_load(m_f3, m_off, dmem_rdata_i));
            m_busy = 0;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit v, input logic [4:0] r, input bit w, input logic [1:0] sel,
                        input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc);
      valid_i = v; rd_i = r; regwren_i = w; wbsel_i = sel; funct3_i = f3; alu_res_i = alu; pc_i = pc;
   endtask

   task automatic idle_in();
      drive(0, 0, 0, 0, 0, 0, 0);
      dmem_rvalid_i = 0; dmem_rdata_i = 0;
   endtask

   task automatic test_reset();
      rst = 0;
      drive(1, 5'd9, 1, 2'd0, 3'd0, 32'hAAAA, 32'h0);
      dmem_rvalid_i = 1; dmem_rdata_i = 32'h5555;
      tick(); tick();
      rst = 1; idle_in();
      total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0h want=1", ready_o); end
      total++; if (rd_o !== 5'd0) begin bad++; $display("FAIL reset_rd got=%0h want=0", rd_o); end
      total++; if (datawb_o !== 32'd0) begin bad++; $display("FAIL reset_data got=%h want=0", datawb_o); end
      total++; if (regwren_o !== 1'b0 || retire_o !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%0h/%0h want=0/0", regwren_o, retire_o); end
      total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL reset_instret got=%0h want=0", instret_o); end
   endtask

   task automatic test_alu_pc4();
      drive(1, 5'd5, 1, 2'd0, 3'd0, 32'h1234, 32'h0);
      tick();
      total++; if (regwren_o !== 1'b1 || rd_o !== 5'd5 || datawb_o !== 32'h1234 || retire_o !== 1'b1) begin
         bad++; $display("FAIL alu_commit got=%0h/%0d/%h/%0h want=1/5/00001234/1", regwren_o, rd_o, datawb_o, retire_o); end
      drive(1, 5'd1, 1, 2'd2, 3'd0, 32'h7777, 32'h100);
      tick();
      total++; if (datawb_o !== 32'h104 || rd_o !== 5'd1 || regwren_o !== 1'b1) begin
         bad++; $display("FAIL jal_pc4 got=%h rd=%0d want=00000104 rd=1", datawb_o, rd_o); end
      drive(1, 5'd1, 1, 2'd2, 3'd0, 32'h7777, 32'hFFFFFFFC);
      tick();
      total++; if (datawb_o !== 32'h0) begin bad++; $display("FAIL pc4_wrap got=%h want=00000000", datawb_o); end
      drive(1, 5'd3, 1, 2'd3, 3'd0, 32'hCAFE, 32'h200);
      tick();
      total++; if (datawb_o !== 32'hCAFE) begin bad++; $display("FAIL sel3_alu got=%h want=0000cafe", datawb_o); end
      idle_in();
      tick();
      total++; if (regwren_o !== 1'b0 || retire_o !== 1'b0 || datawb_o !== 32'hCAFE || rd_o !== 5'd3) begin
         bad++; $display("FAIL hold got=%0h/%0h/%h/%0d want=0/0/0000cafe/3", regwren_o, retire_o, datawb_o, rd_o); end
   endtask

   task automatic test_loads();
      logic [2:0]  f3 [8] = '{3'b000, 3'b100, 3'b101, 3'b001, 3'b010, 3'b001, 3'b011, 3'b101};
      logic [1:0]  of [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd3, 2'd2, 2'd3};
      logic [31:0] rw [8] = '{32'h00800000, 32'h00800000, 32'hBEEF0000, 32'hBEEF0000,
                             32'h12345678, 32'hAB000000, 32'h87654321, 32'hFF000000};
      logic [31:0] ex [8] = '{32'hFFFFFF80, 32'h00000080, 32'h0000BEEF, 32'hFFFFBEEF,
                             32'h12345678, 32'h000000AB, 32'h87654321, 32'h000000FF};
      for (int i = 0; i < 8; i++) begin
         drive(1, 5'd10 + 5'(i), 1, 2'd1, f3[i], 32'h1000 + 32'(of[i]), 32'h0);
         tick();
         total++; if (ready_o !== 1'b0 || retire_o !== 1'b0) begin
            bad++; $display("FAIL load_accept[%0d] ready=%0h retire=%0h want 0/0", i, ready_o, retire_o); end
         idle_in(); dmem_rvalid_i = 1; dmem_rdata_i = rw[i];
         tick();
         total++; if (datawb_o !== ex[i] || regwren_o !== 1'b1 || rd_o !== 5'd10 + 5'(i) || ready_o !== 1'b1) begin
            bad++; $display("FAIL load_data[%0d] got=%h wren=%0h rd=%0d rdy=%0h want=%h/1/%0d/1", i, datawb_o, regwren_o, rd_o, ready_o, ex[i], 10 + i); end
         idle_in();
      end
   endtask

   task automatic test_load_latency();
      int retires = 0;
      drive(1, 5'd7, 1, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      drive(1, 5'd8, 1, 2'd0, 3'd0, 32'h9999, 32'h0);
      for (int c = 0; c < 3; c++) begin
         tick();
         total++; if (ready_o !== 1'b0 || retire_o !== 1'b0) begin
            bad++; $display("FAIL wait_stall[%0d] ready=%0h retire=%0h want 0/0", c, ready_o, retire_o); end
      end
      idle_in(); dmem_rvalid_i = 1; dmem_rdata_i = 32'h0BADF00D;
      total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL rvalid_cycle_ready got=%0h want=0", ready_o); end
      tick();
      retires += int'(retire_o);
      total++; if (rd_o !== 5'd7 || datawb_o !== 32'h0BADF00D) begin
         bad++; $display("FAIL late_load got rd=%0d %h want rd=7 0badf00d", rd_o, datawb_o); end
      idle_in();
      for (int c = 0; c < 3; c++) begin tick(); retires += int'(retire_o); end
      total++; if (retires != 1) begin bad++; $display("FAIL late_load_count got=%0d want=1", retires); end
   endtask

   task automatic test_rd0_stray();
      drive(1, 5'd0, 1, 2'd0, 3'd0, 32'hDEAD, 32'h0);
      tick();
      total++; if (regwren_o !== 1'b0 || retire_o !== 1'b1 || datawb_o !== 32'hDEAD) begin
         bad++; $display("FAIL rd0 got wren=%0h retire=%0h data=%h want 0/1/0000dead", regwren_o, retire_o, datawb_o); end
      idle_in(); dmem_rvalid_i = 1; dmem_rdata_i = 32'h5A5A5A5A;
      tick();
      total++; if (regwren_o !== 1'b0 || retire_o !== 1'b0 || datawb_o !== 32'hDEAD) begin
         bad++; $display("FAIL stray_rvalid got wren=%0h retire=%0h data=%h want 0/0/0000dead", regwren_o, retire_o, datawb_o); end
      idle_in();
   endtask

   task automatic test_reset_in_wait();
      drive(1, 5'd4, 1, 2'd1, 3'b010, 32'h0, 32'h0);
      tick();
      idle_in(); rst = 0; dmem_rvalid_i = 1; dmem_rdata_i = 32'h11111111;
      tick();
      rst = 1;
      tick();
      total++; if (retire_o !== 1'b0 || ready_o !== 1'b1 || datawb_o !== 32'd0) begin
         bad++; $display("FAIL reset_wait got retire=%0h ready=%0h data=%h want 0/1/0", retire_o, ready_o, datawb_o); end
      idle_in();
      tick();
      total++; if (retire_o !== 1'b0) begin bad++; $display("FAIL reset_wait_late got=%0h want=0", retire_o); end
   endtask

   task automatic test_back_to_back();
      int n = 0;
      for (int i = 0; i < 10; i++) begin
         drive(1, 5'(i + 1), 1, 2'(i % 2 * 2), 3'd0, 32'(i * 3), 32'(i * 16));
         tick();
         n += int'(retire_o);
      end
      idle_in();
      total++; if (n != 10) begin bad++; $display("FAIL b2b_retires got=%0d want=10", n); end
`ifdef WB_RETIRE_CNT_EN
      total++; if (instret_o !== 64'd10) begin bad++; $display("FAIL instret10 got=%0d want=10", instret_o); end
`else
      total++; if (instret_o !== 64'd0) begin bad++; $display("FAIL instret_off got=%0d want=0", instret_o); end
`endif
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 59) != 0);
         drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), $urandom, $urandom);
         dmem_rvalid_i = ($urandom_range(0, 9) < 4);
         dmem_rdata_i  = $urandom;
         tick();
         total++; if (ready_o !== !m_busy) begin bad++; $display("FAIL rnd_ready[%0d] got=%0h want=%0h", c, ready_o, !m_busy); end
         total++; if (retire_o !== e_retire || regwren_o !== e_wren) begin
            bad++; $display("FAIL rnd_pulses[%0d] got=%0h/%0h want=%0h/%0h", c, retire_o, regwren_o, e_retire, e_wren); end
         total++; if (rd_o !== e_rd || datawb_o !== e_data) begin
            bad++; $display("FAIL rnd_commit[%0d] got rd=%0d %h want rd=%0d %h", c, rd_o, datawb_o, e_rd, e_data); end
         total++; if (instret_o !== exp_instret()) begin
            bad++; $display("FAIL rnd_instret[%0d] got=%0d want=%0d", c, instret_o, exp_instret()); end
      end
      rst = 1; idle_in();
   endtask

   initial begin
      m_busy = 0; m_cnt = 0; e_rd = 0; e_data = 0; e_wren = 0; e_retire = 0;
      m_rd = 0; m_wren = 0; m_f3 = 0; m_off = 0;
      idle_in();
      test_reset();
      test_alu_pc4();
      test_loads();
      test_load_latency();
      test_rd0_stray();
      test_reset_in_wait();
      test_back_to_back();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
